// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for a 16-bit Fibonacci LFSR stream (taps 4/12/15, shift left, new bit at bit 0).
// Self-synchronises from the serial stream, verifies a run of predictions, then tracks bit errors while locked.
module lfsr_stream_checker #(
    parameter int LOCK_CNT   = 32,
    parameter int ERR_THRESH = 4,
    parameter int WIN        = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_lost,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    // Handshake: bit_in is consumed on every cycle with bit_valid=1; there is no ready,
    // the source never stalls, and cycles with bit_valid=0 leave all state untouched.

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int FILL_W = 5;
    localparam int VER_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN + 1);
    localparam int WERR_W = $clog2(ERR_THRESH + 1);

    state_t             state_q, state_d;
    logic [15:0]        r_q, r_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [VER_W-1:0]   ver_q, ver_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic               locked_d, err_pulse_d, sync_lost_d;
    logic [CNT_W-1:0]   err_count_d;

    logic               pred;
    logic               mismatch;
    logic [15:0]        r_shift_in;
    logic [15:0]        r_free_run;
    logic [WERR_W-1:0]  werr_inc;

    assign pred       = r_q[4] ^ r_q[12] ^ r_q[15];
    assign mismatch   = bit_in ^ pred;
    assign r_shift_in = {r_q[14:0], bit_in};
    assign r_free_run = {r_q[14:0], pred};
    assign werr_inc   = werr_q + WERR_W'(mismatch);
    assign state      = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HUNT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        fill_d      = fill_q;
        ver_d       = ver_q;
        win_d       = win_q;
        werr_d      = werr_q;
        locked_d    = locked;
        err_pulse_d = 1'b0;
        sync_lost_d = 1'b0;
        err_count_d = err_count;

        if (bit_valid) begin
            case (state_q)
                HUNT: begin
                    r_d = r_shift_in;
                    if (fill_q == FILL_W'(15)) begin
                        fill_d = '0;
                        // All-zero is the LFSR lock-up state; keep hunting.
                        if (r_shift_in != 16'd0) begin
                            state_d = VERIFY;
                            ver_d   = '0;
                        end
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    r_d = r_free_run;
                    if (mismatch) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (ver_q == VER_W'(LOCK_CNT - 1)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        win_d    = '0;
                        werr_d   = '0;
                    end else begin
                        ver_d = ver_q + VER_W'(1);
                    end
                end
                LOCKED: begin
                    r_d         = r_free_run;
                    err_pulse_d = mismatch;
                    if (mismatch && (err_count != '1)) err_count_d = err_count + CNT_W'(1);
                    // Threshold is tested before the window wrap so the last bit of a window still counts.
                    if (werr_inc == WERR_W'(ERR_THRESH)) begin
                        state_d     = HUNT;
                        locked_d    = 1'b0;
                        sync_lost_d = 1'b1;
                        fill_d      = '0;
                    end else if (win_q == WIN_W'(WIN - 1)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + WIN_W'(1);
                        werr_d = werr_inc;
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                    fill_d   = '0;
                end
            endcase
        end

        if (clear_err) err_count_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            fill_q    <= '0;
            ver_q     <= '0;
            win_q     <= '0;
            werr_q    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            sync_lost <= 1'b0;
            err_count <= '0;
        end else begin
            r_q       <= r_d;
            fill_q    <= fill_d;
            ver_q     <= ver_d;
            win_q     <= win_d;
            werr_q    <= werr_d;
            locked    <= locked_d;
            err_pulse <= err_pulse_d;
            sync_lost <= sync_lost_d;
            err_count <= err_count_d;
        end
    end

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Receive-side partner of the game's 16-bit Fibonacci LFSR random generator.
- The generator's feedback is bit4^bit12^bit15. It shifts left and inserts the new bit at bit 0.
- This block takes the generator's inserted bit stream serially, self-synchronises a local copy of the LFSR and then checks every following bit.
- It reports lock status and bit errors for link and board bring-up, and is used to confirm that both ends produce identical random streams.

Parameters:
- LOCK_CNT, 32: consecutive correct predictions needed in VERIFY before declaring lock.
- ERR_THRESH, 4: errors within one window that force loss of sync.
- WIN, 64: length of the error-rate window in valid bits.
- CNT_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_valid  in  1  bit_in is sampled on this cycle; there is no backpressure.
- bit_in  in  1  serial LFSR bit, equal to the generator's newly inserted bit 0.
- clear_err  in  1  synchronous clear of err_count.
- locked  out  1  high while in the LOCKED state.
- err_pulse  out  1  one-cycle pulse per mismatched bit in LOCKED.
- sync_lost  out  1  one-cycle pulse on the LOCKED->HUNT transition.
- err_count  out  CNT_W  saturating count of bit errors in LOCKED.
- state  out  2  HUNT=0, VERIFY=1, LOCKED=2.

Behaviour:
- Reset (async, rst_n=0):
  - state=HUNT; locked=0, err_pulse=0, sync_lost=0, err_count=0.
  - Local register r, fill counter, verify counter, window counter and window-error counter all go to 0.
- All outputs are registered. Only cycles with bit_valid=1 advance any state; with bit_valid=0, pulses drop to 0 and everything else holds.
- Prediction: p = r[4]^r[12]^r[15].
- HUNT:
  - On each valid bit: r <= {r[14:0], bit_in}; increment the fill counter.
  - After the 16th bit:
    - If the resulting r is all-zero (an illegal LFSR state), clear the fill counter and stay in HUNT.
    - Otherwise go to VERIFY with the verify counter at 0.
- VERIFY:
  - On each valid bit, compare bit_in with p, then r <= {r[14:0], p}. The register free-runs on the prediction.
  - Mismatch: go to HUNT with the fill counter at 0. No err_pulse and no err_count change.
  - Match: increment the verify counter.
  - On the LOCK_CNT-th match: go to LOCKED, with locked=1 on the following cycle; clear the window counter and window-error counter.
- LOCKED:
  - r free-runs on p, so a single corrupted bit does not propagate.
  - Mismatch:
    - err_pulse=1 on the next cycle.
    - err_count increments, saturating at all-ones.
    - The window-error counter increments.
  - Window counter counts valid bits. On the WIN-th bit, both window counters clear; that bit's error is evaluated before the clear.
  - When the window-error count reaches ERR_THRESH: go to HUNT; sync_lost=1 for one cycle, locked=0 in that same cycle, fill counter=0. The error that triggered this still produces err_pulse and err_count++.
- clear_err:
  - Takes priority over an increment in the same cycle; err_count becomes 0 and the simultaneous error is not counted.
  - err_pulse still asserts for that error.
  - Has no effect on state or the window counters.
- err_count is preserved across loss of sync. Only reset or clear_err zeroes it.
- Deasserting rst_n mid-operation returns the block to HUNT immediately. The full 16+LOCK_CNT bit re-acquisition is required afterwards.
- Latency: locked rises 1 cycle after the (16+LOCK_CNT)-th valid bit of a clean stream (the 48th with defaults).
- Implementation size: 3-state FSM, a 16-bit register, and fill/verify/window/error counters sized with $clog2 from the parameters.

Test Plan:
- Clean lock: generator seeded with 27581 (0x6BBD) drives bit_valid=1 every cycle. Require state=VERIFY after bit 16, locked=1 one cycle after bit 48, err_count=0 over 1000 further bits.
- Single error: after lock, invert bit 100. Require err_pulse high for exactly 1 cycle, err_count=1, locked stays 1, no further errors on subsequent clean bits.
- Sync loss: after lock, invert 4 bits within one 64-bit window. Require sync_lost pulse and locked=0 together, state=HUNT, err_count=4. Re-lock 48 valid bits later.
- Window boundary: 3 errors in window 1 and 3 in window 2. Require locked stays 1, err_count=6. Then 4 all-ones-stuck errors near the saturation limit with CNT_W=3 forced: err_count holds at 7.
- Illegal input: hold bit_in=0 for 200 valid bits. Require state stays HUNT, locked=0, no pulses. A corrupted bit during VERIFY returns to HUNT with err_count unchanged.
- Gaps and reset: clean stream with bit_valid toggling 1/0. Require lock after 48 valid bits regardless of gaps. clear_err coincident with an error gives err_count=0 with err_pulse=1. rst_n low mid-LOCKED gives immediate locked=0, err_count=0, state=HUNT.
